// File: rtl/dma_pkg.sv
// dma_pkg: shared widths, FSM state codes, register offsets and config struct for the DMA engine
package dma_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_REQ     = 3'd1;
  localparam logic [2:0] ST_RD      = 3'd2;
  localparam logic [2:0] ST_RD_WAIT = 3'd3;
  localparam logic [2:0] ST_WR      = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;
  localparam logic [3:0] REG_START   = 4'h0;
  localparam logic [3:0] REG_INTR    = 4'h1;
  localparam logic [3:0] REG_INTR_EN = 4'h2;
  localparam logic [3:0] REG_SRC     = 4'h3;
  localparam logic [3:0] REG_DST     = 4'h4;
  localparam logic [3:0] REG_SIZE    = 4'h5;
  localparam logic [3:0] REG_STATUS  = 4'h6;
  typedef struct packed {
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [ADDR_W-1:0] size;
  } cfg_t;
endpackage

// File: rtl/dma_if.sv
// dma_if: system-bus signals seen by the DMA, both its slave register port and its master port
interface dma_if;
  import dma_pkg::*;
  logic              s_sel;
  logic              s_wr;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_din;
  logic [DATA_W-1:0] s_dout;
  logic              m_req;
  logic              m_grant;
  logic              m_wr;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_dout;
  logic [DATA_W-1:0] m_din;
  logic              interrupt;
  modport slave (
    input  s_sel, s_wr, s_addr, s_din, m_grant, m_din,
    output s_dout, m_req, m_wr, m_addr, m_dout, interrupt
  );
  modport master (
    output s_sel, s_wr, s_addr, s_din, m_grant, m_din,
    input  s_dout, m_req, m_wr, m_addr, m_dout, interrupt
  );
endinterface

// File: rtl/dma_regfile.sv
// dma_regfile: slave register window (config, START pulse, INTR/INTR_EN, registered read data)
module dma_regfile
  import dma_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s_sel,
  input  logic              s_wr,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_din,
  input  logic              busy,
  input  logic              done_set,
  output logic [DATA_W-1:0] s_dout,
  output cfg_t              cfg,
  output logic              start,
  output logic              intr,
  output logic              intr_en
);
  logic [3:0] a;
  logic wr, rd, cfg_wr, in_unused;
  logic [DATA_W-1:0] rd_data;
  assign a = s_addr[3:0];
  assign wr = s_sel & s_wr;
  assign rd = s_sel & ~s_wr;
  assign cfg_wr = wr & ~busy;
  assign start = cfg_wr && a == REG_START && s_din[0];
  assign in_unused = ^{s_addr[ADDR_W-1:4], s_din[DATA_W-1:ADDR_W]};
  always_comb
    rd_data = a == REG_INTR    ? DATA_W'(intr) :
              a == REG_INTR_EN ? DATA_W'(intr_en) :
              a == REG_SRC     ? DATA_W'(cfg.src) :
              a == REG_DST     ? DATA_W'(cfg.dst) :
              a == REG_SIZE    ? DATA_W'(cfg.size) :
              a == REG_STATUS  ? DATA_W'(busy) : '0;
  always_ff @(posedge clk)
    if (!reset_n) begin
      cfg     <= '0;
      intr    <= 1'b0;
      intr_en <= 1'b0;
      s_dout  <= '0;
    end else begin
      if (cfg_wr && a == REG_SRC) cfg.src <= s_din[ADDR_W-1:0];
      if (cfg_wr && a == REG_DST) cfg.dst <= s_din[ADDR_W-1:0];
      if (cfg_wr && a == REG_SIZE) cfg.size <= s_din[ADDR_W-1:0];
      // completion wins over a simultaneous clear
      intr <= done_set | (intr & ~(wr && a == REG_INTR && !s_din[0]));
      if (wr && a == REG_INTR_EN) intr_en <= s_din[0];
      if (rd) s_dout <= rd_data;
    end
endmodule

// File: rtl/dma_engine.sv
// dma_engine: single-channel block copy over the shared bus, slave registers plus master FSM
module dma_engine
  import dma_pkg::*;
(
  input logic  clk,
  input logic  reset_n,
  dma_if.slave bus
);
  logic [2:0] state;
  logic [ADDR_W-1:0] src_cnt, dst_cnt, rem_cnt;
  logic [DATA_W-1:0] data_reg;
  cfg_t cfg;
  logic start, intr, intr_en, on_bus;
  dma_regfile u_regs (
    .clk      (clk),
    .reset_n  (reset_n),
    .s_sel    (bus.s_sel),
    .s_wr     (bus.s_wr),
    .s_addr   (bus.s_addr),
    .s_din    (bus.s_din),
    .busy     (state != ST_IDLE),
    .done_set (state == ST_DONE),
    .s_dout   (bus.s_dout),
    .cfg      (cfg),
    .start    (start),
    .intr     (intr),
    .intr_en  (intr_en)
  );
  assign on_bus = state == ST_RD || state == ST_RD_WAIT || state == ST_WR;
  assign bus.m_req = on_bus || state == ST_REQ;
  assign bus.m_wr = state == ST_WR;
  assign bus.m_addr = state == ST_WR ? dst_cnt : on_bus ? src_cnt : '0;
  assign bus.m_dout = state == ST_WR ? data_reg : '0;
  assign bus.interrupt = intr & intr_en;
  // losing grant mid-word simply stalls the current state
  always_ff @(posedge clk)
    if (!reset_n) begin
      state    <= ST_IDLE;
      src_cnt  <= '0;
      dst_cnt  <= '0;
      rem_cnt  <= '0;
      data_reg <= '0;
    end else begin
      case (state)
        ST_IDLE:
          if (start) begin
            src_cnt <= cfg.src;
            dst_cnt <= cfg.dst;
            rem_cnt <= cfg.size;
            state   <= cfg.size == '0 ? ST_DONE : ST_REQ;
          end
        ST_REQ:     if (bus.m_grant) state <= ST_RD;
        ST_RD:      if (bus.m_grant) state <= ST_RD_WAIT;
        ST_RD_WAIT:
          if (bus.m_grant) begin
            data_reg <= bus.m_din;
            state    <= ST_WR;
          end
        ST_WR:
          if (bus.m_grant) begin
            src_cnt <= src_cnt + 1'b1;
            dst_cnt <= dst_cnt + 1'b1;
            rem_cnt <= rem_cnt - 1'b1;
            state   <= rem_cnt == 'd1 ? ST_DONE : ST_RD;
          end
        default: state <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_dma_engine.sv
// tb_dma_engine: randomized and directed checks of dma_engine against a work-unit reference model
module tb_dma_engine;
  import dma_pkg::*;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  dma_if bus();
  dma_engine dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;

  logic [31:0] mem [0:65535];
  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 0;
  bit rand_grant = 0;
  bit rand_rd = 0;

  bit md_active = 0, md_done = 0, md_intr = 0, md_en = 0;
  int md_k = 0, md_n = 0;
  logic [15:0] md_src = '0, md_dst = '0, r_src = '0, r_dst = '0, r_size = '0;
  logic [31:0] md_sdout = '0;
  logic [31:0] md_data [0:15];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Slave memory: registered read data, write when the master owns the bus
  always @(posedge clk) begin
    bus.m_din <= mem[bus.m_addr];
    if (bus.m_req && bus.m_wr && bus.m_grant) mem[bus.m_addr] = bus.m_dout;
  end

  // Model: a transfer is 3N+1 granted bus cycles (request + read/wait/write per word), then one done cycle
  always @(negedge clk) begin
    logic [3:0] a;
    bit wr, rd, busy;
    int w, p;
    logic [49:0] exp_bus;
    if (chk_on) begin
      exp_bus = '0;
      if (md_active && md_k == 0) exp_bus = {2'b10, 48'h0};
      else if (md_active) begin
        w = (md_k - 1) / 3;
        p = (md_k - 1) % 3;
        exp_bus = p == 2 ? {2'b11, md_dst + 16'(w), md_data[w]} : {2'b10, md_src + 16'(w), 32'h0};
      end
      chk("bus", 64'({bus.m_req, bus.m_wr, bus.m_addr, bus.m_dout}), 64'(exp_bus));
      chk("interrupt", 64'(bus.interrupt), 64'(md_intr & md_en));
      chk("s_dout", 64'(bus.s_dout), 64'(md_sdout));
    end
    if (!reset_n) begin
      md_active = 0; md_done = 0; md_intr = 0; md_en = 0; md_k = 0; md_n = 0;
      md_src = '0; md_dst = '0; r_src = '0; r_dst = '0; r_size = '0; md_sdout = '0;
    end else begin
      a = bus.s_addr[3:0];
      wr = bus.s_sel && bus.s_wr;
      rd = bus.s_sel && !bus.s_wr;
      busy = md_active || md_done;
      if (rd)
        md_sdout = a == 4'd1 ? 32'(md_intr) : a == 4'd2 ? 32'(md_en) : a == 4'd3 ? 32'(r_src) :
                   a == 4'd4 ? 32'(r_dst) : a == 4'd5 ? 32'(r_size) : a == 4'd6 ? 32'(busy) : 32'h0;
      md_intr = md_done || (md_intr && !(wr && a == 4'd1 && !bus.s_din[0]));
      md_done = 0;
      if (md_active && bus.m_grant) begin
        md_k++;
        if (md_k == 3 * md_n + 1) begin
          md_active = 0;
          md_done = 1;
        end
      end
      if (wr && a == 4'd2) md_en = bus.s_din[0];
      if (wr && !busy) begin
        if (a == 4'd0 && bus.s_din[0]) begin
          md_src = r_src; md_dst = r_dst; md_n = int'(r_size); md_k = 0;
          md_done = r_size == 16'h0;
          md_active = r_size != 16'h0;
          for (int i = 0; i < 16 && i < md_n; i++) md_data[i] = mem[r_src + 16'(i)];
        end
        if (a == 4'd3) r_src = bus.s_din[15:0];
        if (a == 4'd4) r_dst = bus.s_din[15:0];
        if (a == 4'd5) r_size = bus.s_din[15:0];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_grant) bus.m_grant = $urandom_range(0, 3) != 0;
    if (rand_rd) begin
      bus.s_sel = $urandom_range(0, 1) == 1;
      bus.s_wr = 1'b0;
      bus.s_addr = 16'($urandom);
    end
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [31:0] d);
    bus.s_sel = 1'b1; bus.s_wr = 1'b1; bus.s_addr = {12'h0, a}; bus.s_din = d;
    tick();
    bus.s_sel = 1'b0; bus.s_wr = 1'b0;
  endtask

  task automatic rd_reg(input logic [3:0] a, input logic [31:0] e, input string nm);
    bus.s_sel = 1'b1; bus.s_wr = 1'b0; bus.s_addr = {12'h0, a};
    tick();
    bus.s_sel = 1'b0;
    chk(nm, 64'(bus.s_dout), 64'(e));
  endtask

  task automatic wait_irq(output int n);
    n = 0;
    while (!bus.interrupt && n < 300) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((md_active || md_done) && n < 2000) begin
      tick();
      n++;
    end
    bus.s_sel = 1'b0;
    chk("idle_timeout", 64'(md_active || md_done), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n2;
    logic [15:0] s, d;
    logic [31:0] cap [0:7];
    for (int i = 0; i < 65536; i++) mem[i] = $urandom;
    for (int i = 0; i < 4; i++) mem[i] = 32'h11 * (i + 1);
    mem[16'hFFFF] = 32'hAAAA0001;
    bus.s_sel = 0; bus.s_wr = 0; bus.s_addr = '0; bus.s_din = '0; bus.m_grant = 1'b1;
    tick(); tick();
    reset_n = 1'b1;
    chk_on = 1;
    chk("reset_m_req", 64'(bus.m_req), 64'(0));
    chk("reset_s_dout", 64'(bus.s_dout), 64'(0));

    wr_reg(4'h3, 32'h0000);
    wr_reg(4'h4, 32'h0100);
    wr_reg(4'h5, 32'd4);
    rd_reg(4'h3, 32'h0000, "rd_src");
    rd_reg(4'h4, 32'h0100, "rd_dst");
    rd_reg(4'h5, 32'h0004, "rd_size");
    rd_reg(4'h7, 32'h0, "rd_unmapped");

    wr_reg(4'h2, 32'h1);
    wr_reg(4'h0, 32'h1);
    wait_irq(n);
    chk("copy_latency", 64'(n), 64'(14));
    for (int i = 0; i < 4; i++) chk("copy_data", 64'(mem[16'h0100 + 16'(i)]), 64'(32'h11 * (i + 1)));
    wr_reg(4'h1, 32'h0);
    chk("intr_clear", 64'(bus.interrupt), 64'(0));

    wr_reg(4'h4, 32'h0140);
    wr_reg(4'h0, 32'h1);
    repeat (6) tick();
    bus.m_grant = 1'b0;
    tick();
    chk("stall_frozen", 64'({bus.m_req, bus.m_wr, bus.m_addr, bus.m_dout}), 64'({2'b11, 16'h0141, 32'h22}));
    tick(); tick();
    bus.m_grant = 1'b1;
    wait_irq(n2);
    chk("stall_latency", 64'(9 + n2), 64'(17));
    for (int i = 0; i < 4; i++) chk("stall_data", 64'(mem[16'h0140 + 16'(i)]), 64'(32'h11 * (i + 1)));
    wr_reg(4'h1, 32'h0);

    wr_reg(4'h5, 32'h0);
    wr_reg(4'h0, 32'h1);
    tick();
    chk("size0_intr", 64'(bus.interrupt), 64'(1));
    wr_reg(4'h1, 32'h0);
    chk("size0_clear", 64'(bus.interrupt), 64'(0));

    wr_reg(4'h5, 32'd4);
    wr_reg(4'h4, 32'h0180);
    wr_reg(4'h0, 32'h1);
    tick(); tick();
    wr_reg(4'h3, 32'h0200);
    wr_reg(4'h0, 32'h1);
    wait_idle();
    for (int i = 0; i < 4; i++) chk("busy_start_data", 64'(mem[16'h0180 + 16'(i)]), 64'(32'h11 * (i + 1)));
    rd_reg(4'h3, 32'h0000, "src_kept");
    wr_reg(4'h1, 32'h0);

    wr_reg(4'h3, 32'hFFFF);
    wr_reg(4'h4, 32'h0300);
    wr_reg(4'h5, 32'd2);
    wr_reg(4'h0, 32'h1);
    wait_idle();
    chk("wrap_w0", 64'(mem[16'h0300]), 64'(32'hAAAA0001));
    chk("wrap_w1", 64'(mem[16'h0301]), 64'(32'h11));
    wr_reg(4'h1, 32'h0);

    wr_reg(4'h3, 32'h0000);
    wr_reg(4'h4, 32'h0400);
    wr_reg(4'h5, 32'd4);
    wr_reg(4'h0, 32'h1);
    repeat (4) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("rst_m_req", 64'(bus.m_req), 64'(0));
    chk("rst_interrupt", 64'(bus.interrupt), 64'(0));
    rd_reg(4'h6, 32'h0, "rst_status");

    for (int t = 0; t < 12; t++) begin
      s = 16'($urandom_range(16'h1000, 16'h6FFF));
      d = s + 16'h8000;
      n = $urandom_range(0, 8);
      for (int i = 0; i < 8; i++) cap[i] = mem[s + 16'(i)];
      wr_reg(4'h2, 32'($urandom_range(0, 1)));
      wr_reg(4'h3, 32'(s));
      wr_reg(4'h4, 32'(d));
      wr_reg(4'h5, 32'(n));
      rand_grant = 1;
      wr_reg(4'h0, 32'h1);
      rand_rd = 1;
      wait_idle();
      rand_rd = 0;
      rand_grant = 0;
      bus.m_grant = 1'b1;
      for (int i = 0; i < n; i++) chk("rand_data", 64'(mem[d + 16'(i)]), 64'(cap[i]));
      wr_reg(4'h1, 32'h0);
    end

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dma_engine.md
# dma_engine

Single-channel DMA controller that sits on the shared system bus in two roles: a bus slave (register window for the CPU/testbench master) and a bus master (the initiator that moves data). Once started, it requests the bus, copies a block of 32-bit words from a source address range to a destination address range through ordinary bus read/write cycles, then releases the bus and raises an interrupt.

## Interface
- ADDR_W, 16, bus address width
- DATA_W, 32, bus data width
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- s_sel  in  1  slave select from bus address decoder
- s_wr  in  1  slave write strobe (1 = write, 0 = read)
- s_addr  in  ADDR_W  slave address; only s_addr[3:0] decoded
- s_din  in  DATA_W  slave write data
- s_dout  out  DATA_W  slave read data, registered
- m_req  out  1  bus request
- m_grant  in  1  bus grant from arbiter
- m_wr  out  1  master write strobe
- m_addr  out  ADDR_W  master address
- m_dout  out  DATA_W  master write data
- m_din  in  DATA_W  master read data
- interrupt  out  1  transfer-done interrupt (level)

## Operation
- Register map (word offsets, s_addr[3:0]): 0x0 START (W, bit0=1 starts); 0x1 INTR (R bit0; write 0 clears); 0x2 INTR_EN (RW bit0); 0x3 SRC (RW [15:0]); 0x4 DST (RW [15:0]); 0x5 SIZE (RW [15:0], word count); 0x6 STATUS (R, bit0=busy). Unmapped reads return 0; unmapped writes ignored.
- Writes to SRC/DST/SIZE/START while busy are ignored; INTR/INTR_EN writes always accepted.
- interrupt = INTR & INTR_EN.
- FSM states: IDLE, REQ, RD, RD_WAIT, WR, DONE.
- IDLE: START write latches SRC/DST/SIZE into working counters src_cnt, dst_cnt, rem_cnt. SIZE=0 -> go to DONE directly (no bus traffic). Else -> REQ.
- REQ: m_req=1; wait for m_grant=1 -> RD.
- RD: m_req=1, m_wr=0, m_addr=src_cnt -> RD_WAIT.
- RD_WAIT: m_req=1, m_wr=0, m_addr=src_cnt; capture m_din into data_reg at end of cycle -> WR.
- WR: m_req=1, m_wr=1, m_addr=dst_cnt, m_dout=data_reg; at edge src_cnt+1, dst_cnt+1, rem_cnt-1; rem_cnt==1 -> DONE else RD.
- DONE: m_req=0, set INTR -> IDLE.
- Address counters wrap modulo 2^ADDR_W; no boundary checks.
- m_grant dropping while in RD/RD_WAIT/WR freezes the FSM (no counter or data update) until grant returns; m_req stays 1.
- m_dout = 0 and m_addr = 0 whenever not in RD/RD_WAIT/WR.

## Timing
- Reset (edge with reset_n=0): FSM IDLE, all registers 0, s_dout=0, m_req=0, m_wr=0, m_addr=0, m_dout=0, interrupt=0. Reset mid-transfer aborts immediately; no partial write completes after that edge.
- Slave read: s_dout updated at edge where s_sel=1 and s_wr=0; valid next cycle (one-cycle latency, matches other slaves).
- Slave write: takes effect at edge where s_sel=1 and s_wr=1.
- Bus read: slave data on m_din valid the cycle after address presented (RD_WAIT).
- With immediate grant: START edge -> REQ (1 cycle) -> 3 cycles per word -> DONE (1 cycle). N words = 3N+2 cycles from START edge to INTR=1.
- START and INTR-clear in the same transfer: impossible (single slave port); INTR set in DONE takes priority over a simultaneous clear write.
- Each destination write occurs exactly once per word, ascending addresses.

## Structure
- Package dma_pkg: state enum, register offset constants, ADDR_W/DATA_W defaults.
- One sub-module natural: dma_regfile (slave decode, config/INTR/INTR_EN registers, s_dout mux/register); FSM and counters stay in dma_engine.

## Test plan
- Reset: hold reset_n=0 one cycle mid-transfer -> m_req=0, STATUS=0, interrupt=0 next cycle.
- Register access: write SRC=0x0000, DST=0x0100, SIZE=4, read back -> 0x0000, 0x0100, 0x0004; read offset 0x7 -> 0.
- Copy 4 words s0 0x0000..0x0003 (0x11,0x22,0x33,0x44) to s1 0x0100..0x0103, INTR_EN=1, grant immediate -> writes land in order, interrupt=1 exactly 14 cycles after START edge.
- Grant stall: deassert m_grant 3 cycles during WR of word 2 -> m_req held, addresses frozen, final data identical, completion 3 cycles later.
- SIZE=0 start -> no m_req pulse, INTR=1 after 1 cycle; write INTR=0 -> interrupt=0.
- START while busy with SRC=0x0200 -> ignored, transfer continues from original SRC; SRC=0xFFFF, SIZE=2 -> reads 0xFFFF then 0x0000 (wrap).
